// File: rtl/picomips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picomips_pkg
// Description : Shared types and constants for the picoMips sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package picomips_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        HALT    = 2'd3
    } seq_state_t;

    localparam int STAGE_W    = 2;
    localparam int NUM_STAGES = 4;

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : Two-flop synchroniser followed by a run-length debouncer.
//               The level flips after DEB_CYCLES consecutive disagreeing
//               synchronised samples.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous switch into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Count disagreeing samples; flip the level on the DEB_CYCLES-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync_b != level) begin
            if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Four-stage multi-cycle instruction sequencer with branch,
//               halt and handshake-switch stall for the picoMips core.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import picomips_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int LAST_ADDR  = 31,
    parameter int DEB_CYCLES = 4,
    parameter int WAIT_STAGE = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Handshake,
    input  logic                WaitReq,
    input  logic                Branch,
    input  logic [ADDR_W-1:0]   BranchTarget,
    input  logic                Halt,
    output logic [ADDR_W-1:0]   Addr,
    output logic [STAGE_W-1:0]  Stage,
    output logic                Stall,
    output logic                Accept
);

    localparam logic [ADDR_W-1:0]  LAST_A     = ADDR_W'(LAST_ADDR);
    localparam logic [STAGE_W-1:0] WSTAGE     = STAGE_W'(WAIT_STAGE);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [ADDR_W-1:0]   addr_seq;
    logic [STAGE_W-1:0]  stage_nxt;
    logic                accept_nxt;
    logic                hs_level;

    switch_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (Clock),
        .rst   (Reset),
        .raw   (Handshake),
        .level (hs_level)
    );

    assign addr_seq = (Addr == LAST_A) ? '0 : Addr + 1'b1;
    assign Stall    = (state != RUN);

    // State, address, stage and accept registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= RUN;
            Addr   <= '0;
            Stage  <= '0;
            Accept <= 1'b0;
        end else begin
            state  <= state_nxt;
            Addr   <= addr_nxt;
            Stage  <= stage_nxt;
            Accept <= accept_nxt;
        end
    end

    // Next-state logic: stage stepping, end-of-instruction address update,
    // handshake stall and halt.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = Addr;
        stage_nxt  = Stage;
        accept_nxt = 1'b0;
        case (state)
            RUN: begin
                if (Stage == WSTAGE && WaitReq) begin
                    state_nxt = WAIT_HI;
                end else begin
                    stage_nxt = Stage + 1'b1;
                    if (Stage == LAST_STAGE) begin
                        if (Halt) begin
                            state_nxt = HALT;
                            stage_nxt = '0;
                        end else if (Branch) begin
                            addr_nxt = BranchTarget;
                        end else begin
                            addr_nxt = addr_seq;
                        end
                    end
                end
            end
            WAIT_HI: begin
                if (hs_level) state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!hs_level) begin
                    state_nxt  = RUN;
                    accept_nxt = 1'b1;
                    stage_nxt  = Stage + 1'b1;
                    // A wait placed in the last stage still finishes the
                    // instruction when released.
                    if (Stage == LAST_STAGE) addr_nxt = addr_seq;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking scoreboard bench for instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] stage;
        logic       stall;
        logic       acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs;
    logic       wreq;
    logic       br;
    logic [4:0] tgt;
    logic       halt;
    logic [4:0] Addr;
    logic [1:0] Stage;
    logic       Stall;
    logic       Accept;

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";
    exp_t  sb[$];

    always #5 clk = ~clk;

    instr_sequencer #(
        .ADDR_W     (5),
        .LAST_ADDR  (31),
        .DEB_CYCLES (4),
        .WAIT_STAGE (1)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Handshake    (hs),
        .WaitReq      (wreq),
        .Branch       (br),
        .BranchTarget (tgt),
        .Halt         (halt),
        .Addr         (Addr),
        .Stage        (Stage),
        .Stall        (Stall),
        .Accept       (Accept)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s.%s got=%0h expected=%0h at %0t", phase, tag, obs, exp, $time);
    endtask

    task automatic check_all(input exp_t e);
        check("addr",   32'(Addr),   32'(e.addr));
        check("stage",  32'(Stage),  32'(e.stage));
        check("stall",  32'(Stall),  32'(e.stall));
        check("accept", 32'(Accept), 32'(e.acc));
    endtask

    // Push the expectation for the next edge, clock once, pop and compare.
    task automatic tick_expect(input logic [4:0] a, input logic [1:0] s,
                               input logic st, input logic ac);
        exp_t e;
        e = '{addr: a, stage: s, stall: st, acc: ac};
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_all(sb.pop_front());
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 check_all('{addr: 5'd0, stage: 2'd0, stall: 1'b0, acc: 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Sequential run from address 0 stage 0 with no control activity.
    task automatic run_from_zero(input int n);
        for (int k = 1; k <= n; k++) tick_expect(5'(k / 4), 2'(k % 4), 1'b0, 1'b0);
    endtask

    // Full press/release while stalled at (a, s): 10 clocks high, then release;
    // the debounced fall lands 6 edges later and the FSM resumes on the 7th.
    task automatic press_release(input logic [4:0] a, input logic [1:0] s);
        hs = 1'b1;
        for (int i = 0; i < 10; i++) tick_expect(a, s, 1'b1, 1'b0);
        hs = 1'b0;
        for (int i = 0; i < 6; i++) tick_expect(a, s, 1'b1, 1'b0);
        tick_expect(a, s + 2'd1, 1'b0, 1'b1);
        tick_expect(a, s + 2'd2, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; hs = 1'b0; wreq = 1'b0; br = 1'b0; tgt = 5'd0; halt = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: sequential stepping, reset mid-count
        phase = "t1";
        check_all('{addr: 5'd0, stage: 2'd0, stall: 1'b0, acc: 1'b0});
        run_from_zero(6);
        async_reset();
        run_from_zero(12);

        // 2: branch at stage 3, wrap from LAST_ADDR, branch ignored elsewhere
        phase = "t2";
        tick_expect(5'd3, 2'd1, 1'b0, 1'b0);
        tick_expect(5'd3, 2'd2, 1'b0, 1'b0);
        tick_expect(5'd3, 2'd3, 1'b0, 1'b0);
        br = 1'b1; tgt = 5'd31;
        tick_expect(5'd31, 2'd0, 1'b0, 1'b0);
        tgt = 5'd7;
        tick_expect(5'd31, 2'd1, 1'b0, 1'b0);
        tick_expect(5'd31, 2'd2, 1'b0, 1'b0);
        tick_expect(5'd31, 2'd3, 1'b0, 1'b0);
        br = 1'b0;
        tick_expect(5'd0, 2'd0, 1'b0, 1'b0);
        tick_expect(5'd0, 2'd1, 1'b0, 1'b0);
        tick_expect(5'd0, 2'd2, 1'b0, 1'b0);
        tick_expect(5'd0, 2'd3, 1'b0, 1'b0);
        br = 1'b1;
        tick_expect(5'd7, 2'd0, 1'b0, 1'b0);
        br = 1'b0;

        // 3: wait request at stage 1, then press/release
        phase = "t3";
        tick_expect(5'd7, 2'd1, 1'b0, 1'b0);
        wreq = 1'b1;
        for (int i = 0; i < 5; i++) tick_expect(5'd7, 2'd1, 1'b1, 1'b0);
        wreq = 1'b0;
        press_release(5'd7, 2'd1);

        // 4: bouncing switch must not advance out of WAIT_HI
        phase = "t4";
        tick_expect(5'd8, 2'd0, 1'b0, 1'b0);
        wreq = 1'b1;
        tick_expect(5'd8, 2'd1, 1'b0, 1'b0);
        tick_expect(5'd8, 2'd1, 1'b1, 1'b0);
        wreq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hs = (i % 2 == 0);
            tick_expect(5'd8, 2'd1, 1'b1, 1'b0);
        end
        hs = 1'b0;
        for (int i = 0; i < 10; i++) tick_expect(5'd8, 2'd1, 1'b1, 1'b0);
        press_release(5'd8, 2'd1);

        // 5: halt at stage 3 of address 4, only reset leaves it
        phase = "t5";
        br = 1'b1; tgt = 5'd4;
        tick_expect(5'd4, 2'd0, 1'b0, 1'b0);
        br = 1'b0;
        tick_expect(5'd4, 2'd1, 1'b0, 1'b0);
        tick_expect(5'd4, 2'd2, 1'b0, 1'b0);
        tick_expect(5'd4, 2'd3, 1'b0, 1'b0);
        halt = 1'b1;
        tick_expect(5'd4, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            hs = ((i / 8) % 2 == 0);
            tick_expect(5'd4, 2'd0, 1'b1, 1'b0);
        end
        hs = 1'b0;
        halt = 1'b0;
        async_reset();
        tick_expect(5'd0, 2'd1, 1'b0, 1'b0);

        // 6: reset during WAIT_LO discards the pending handshake
        phase = "t6";
        wreq = 1'b1;
        tick_expect(5'd0, 2'd1, 1'b1, 1'b0);
        wreq = 1'b0;
        hs = 1'b1;
        for (int i = 0; i < 9; i++) tick_expect(5'd0, 2'd1, 1'b1, 1'b0);
        hs = 1'b0;
        async_reset();
        run_from_zero(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
